// File: rtl/spi_master_byte.sv
// Byte-wide SPI master, mode 0, MSB first. Each byte is taken over a
// valid/ready handshake; tx_last chooses whether SSEL is released after it.
//
// state     | meaning
// IDLE      | SSEL inactive, ready for a byte
// SETUP     | SSEL active, first MOSI bit presented, SCK low
// HIGH      | SCK high half-period
// LOW       | SCK low half-period after a sample
// WAIT_NEXT | SSEL still active between bytes, ready for a byte
module spi_master_byte #(
  parameter int   CLK_DIV     = 4,
  parameter logic SSEL_ACTIVE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       SCK,
  output logic       SSEL,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_WAIT_NEXT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] half_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic             last_q;
  logic             half_done;

  assign half_done = (half_cnt == CNT_TC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      last_q   <= 1'b0;
      SCK      <= 1'b0;
      SSEL     <= ~SSEL_ACTIVE;
      MOSI     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      tx_ready <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE, S_WAIT_NEXT: begin
          if (tx_valid && tx_ready) begin
            tx_sr    <= tx_data;
            last_q   <= tx_last;
            MOSI     <= tx_data[7];
            SSEL     <= SSEL_ACTIVE;
            SCK      <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (half_done) begin
            half_cnt <= '0;
            SCK      <= 1'b1;
            state    <= S_HIGH;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          // Sample on the edge we drive low; the slave only moves MISO after it.
          if (half_done) begin
            half_cnt <= '0;
            SCK      <= 1'b0;
            rx_sr    <= {rx_sr[6:0], MISO};
            MOSI     <= tx_sr[6];
            tx_sr    <= {tx_sr[6:0], 1'b0};
            bit_cnt  <= bit_cnt + 3'd1;
            state    <= S_LOW;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        S_LOW: begin
          if (half_done) begin
            half_cnt <= '0;
            // bit_cnt wraps to zero after the eighth sample
            if (bit_cnt != 3'd0) begin
              SCK   <= 1'b1;
              state <= S_HIGH;
            end else begin
              rx_data  <= rx_sr;
              rx_valid <= 1'b1;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
              if (last_q) begin
                SSEL  <= ~SSEL_ACTIVE;
                state <= S_IDLE;
              end else begin
                state <= S_WAIT_NEXT;
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Bench for spi_master_byte: per-cycle pin checks against a timing model
// computed from half-period arithmetic, with loopback, constant and slave MISO.
module tb_spi_master_byte;

  localparam int C0 = 2;
  localparam int C1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] tx_data = '0;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sck, ssel, mosi, miso;

  logic [7:0] tx1_data = '0;
  logic       tx1_last = 1'b0;
  logic       tx1_valid = 1'b0;
  logic       tx1_ready;
  logic [7:0] rx1_data;
  logic       rx1_valid;
  logic       busy1;
  logic       sck1, ssel1, mosi1;

  int         miso_mode = 0;   // 0 loopback, 1 constant, 2 slave byte
  logic       miso_const = 1'b0;
  logic       slave_bit = 1'b0;

  int         checks = 0;
  int         failures = 0;
  bit         prev_last = 1'b1;
  logic [7:0] last_rx = '0;

  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? miso_const : slave_bit;

  always #5 clk = ~clk;

  spi_master_byte #(.CLK_DIV(C0), .SSEL_ACTIVE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .SCK(sck), .SSEL(ssel), .MOSI(mosi), .MISO(miso)
  );

  spi_master_byte #(.CLK_DIV(C1), .SSEL_ACTIVE(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx1_data), .tx_last(tx1_last), .tx_valid(tx1_valid), .tx_ready(tx1_ready),
    .rx_data(rx1_data), .rx_valid(rx1_valid), .busy(busy1),
    .SCK(sck1), .SSEL(ssel1), .MOSI(mosi1), .MISO(mosi1)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {SCK, SSEL, MOSI, busy, tx_ready, rx_valid} d cycles after the accept edge.
  function automatic logic [5:0] exp_vec(input int c, input logic sa, input logic [7:0] b,
                                         input logic last, input int d);
    logic act, e_sck, e_mosi, e_ssel;
    int   bi;
    act    = (d < 17 * c);
    e_sck  = (d < 16 * c) && (((d / c) % 2) == 1);
    bi     = 7 - d / (2 * c);
    e_mosi = (d < 16 * c) ? b[bi[2:0]] : 1'b0;
    e_ssel = (act || !last) ? sa : ~sa;
    return {e_sck, e_ssel, e_mosi, act, ~act, (d == 17 * c)};
  endfunction

  function automatic logic [5:0] obs_vec();
    return {sck, ssel, mosi, busy, tx_ready, rx_valid};
  endfunction

  // Called at a negedge; returns at the negedge where rx_valid is expected.
  task automatic xfer(input logic [7:0] d, input logic last, input int mode,
                      input logic [7:0] sbyte, input bit hold);
    logic [7:0] rx_exp;
    logic       sck_prev;
    int         idx;
    rx_exp = (mode == 0) ? d : sbyte;
    chk_eq("ready_before_accept", {31'd0, tx_ready}, 32'd1);
    chk_eq("ssel_before_accept", {31'd0, ssel}, {31'd0, ~prev_last});
    miso_mode  = mode;
    miso_const = sbyte[0];
    slave_bit  = 1'b0;
    sck_prev   = 1'b0;
    idx        = 0;
    tx_data    = d;
    tx_last    = last;
    tx_valid   = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 17 * C0; k++) begin
      @(negedge clk);
      if (hold && k < 17 * C0) begin
        tx_data = 8'h22;
        tx_last = 1'b0;
      end else begin
        tx_valid = 1'b0;
      end
      if (sck && !sck_prev) begin
        slave_bit = sbyte[3'(7 - idx)];
        idx++;
      end
      sck_prev = sck;
      chk_eq($sformatf("pins byte=%02h d=%0d", d, k), {26'd0, obs_vec()},
             {26'd0, exp_vec(C0, 1'b1, d, last, k)});
    end
    chk_eq($sformatf("rx_data byte=%02h", d), {24'd0, rx_data}, {24'd0, rx_exp});
    tx_valid  = 1'b0;
    prev_last = last;
    last_rx   = rx_exp;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk_eq("idle_pins", {26'd0, obs_vec()}, {26'd0, 1'b0, ~prev_last, 4'b0010});
      chk_eq("idle_rx_hold", {24'd0, rx_data}, {24'd0, last_rx});
    end
  endtask

  initial begin
    int rv_seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("reset_pins0", {26'd0, obs_vec()}, {26'd0, 6'b000010});
    chk_eq("reset_rx0", {24'd0, rx_data}, 32'd0);
    chk_eq("reset_pins1", {26'd0, sck1, ssel1, mosi1, busy1, tx1_ready, rx1_valid},
           {26'd0, 6'b010010});
    rst_n = 1'b1;
    idle_cycles(2);

    xfer(8'hA5, 1'b1, 0, 8'h00, 1'b0);
    idle_cycles(2);
    xfer(8'h00, 1'b1, 1, 8'hFF, 1'b0);
    idle_cycles(1);
    xfer(8'hFF, 1'b1, 1, 8'h00, 1'b0);
    idle_cycles(1);
    xfer(8'h3C, 1'b0, 0, 8'h00, 1'b0);
    xfer(8'hC3, 1'b1, 0, 8'h00, 1'b0);
    idle_cycles(2);
    xfer(8'h11, 1'b1, 0, 8'h00, 1'b1);
    idle_cycles(2);

    // Reset after the third SCK rise of 0xF0
    miso_mode = 0;
    tx_data   = 8'hF0;
    tx_last   = 1'b1;
    tx_valid  = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 5 * C0; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      chk_eq($sformatf("pre_reset d=%0d", k), {26'd0, obs_vec()},
             {26'd0, exp_vec(C0, 1'b1, 8'hF0, 1'b1, k)});
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_eq("mid_reset_pins", {26'd0, obs_vec()}, {26'd0, 6'b000010});
    chk_eq("mid_reset_rx", {24'd0, rx_data}, 32'd0);
    rst_n     = 1'b1;
    prev_last = 1'b1;
    last_rx   = 8'h00;
    rv_seen   = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rx_valid) rv_seen++;
    end
    chk_eq("no_rx_valid_after_reset", rv_seen, 32'd0);
    xfer(8'h81, 1'b1, 0, 8'h00, 1'b0);
    idle_cycles(1);

    for (int i = 0; i < 12; i++) begin
      logic [7:0] d, sb;
      logic       last;
      int         mode;
      d    = 8'($urandom);
      sb   = 8'($urandom);
      last = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      if (mode == 1) sb = {8{sb[0]}};
      xfer(d, last, mode, sb, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
    xfer(8'h96, 1'b1, 2, 8'h6B, 1'b0);
    idle_cycles(1);

    // CLK_DIV=1, active-low SSEL, loopback
    tx1_data  = 8'h5A;
    tx1_last  = 1'b1;
    tx1_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 17 * C1; k++) begin
      @(negedge clk);
      tx1_valid = 1'b0;
      chk_eq($sformatf("div1 pins d=%0d", k),
             {26'd0, sck1, ssel1, mosi1, busy1, tx1_ready, rx1_valid},
             {26'd0, exp_vec(C1, 1'b0, 8'h5A, 1'b1, k)});
    end
    chk_eq("div1_rx_data", {24'd0, rx1_data}, 32'h5A);
    @(negedge clk);
    chk_eq("div1_rx_valid_pulse", {31'd0, rx1_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
